// File: rtl/clk_div_if.sv
// Configuration handshake bundle for clk_div_ctrl.
// master drives the request, slave answers with cfg_ready.
interface clk_div_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_en;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_en,
    output cfg_ready
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-free runtime-programmable clock divider; updates land on period edges.
// Define CLK_DIV_DUTY50_EN for exact 50% duty on odd ratios.
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 5
) (
  input  logic             clk,
  input  logic             rstn,
  clk_div_if.slave         cfg,
  output logic             clk_out,
  output logic             div_active,
  output logic [CNT_W-1:0] cur_div,
  output logic             cfg_err,
  output logic             period_tick
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] div_nx;
  logic [CNT_W-1:0] pdiv;
  logic [CNT_W-1:0] pdiv_nx;
  logic             pen;
  logic             pen_nx;
  logic             acc;
  logic             legal;
  logic             bnd;
  logic             app_en;
  logic [CNT_W-1:0] app_div;
  logic [CNT_W:0]   half_nx;
  logic             clk_p;
  logic             clk_p_nx;
  logic             tick_nx;

  always_comb begin
    acc      = cfg.cfg_valid && cfg.cfg_ready;
    legal    = acc && (cfg.cfg_div >= CNT_W'(2));
    bnd      = (state != IDLE) && (cnt == cur_div - 1'b1);
    state_nx = state;
    cnt_nx   = cnt;
    div_nx   = cur_div;
    pdiv_nx  = pdiv;
    pen_nx   = pen;
    app_en   = (state == PEND) ? pen  : cfg.cfg_en;
    app_div  = (state == PEND) ? pdiv : cfg.cfg_div;
    unique case (state)
      IDLE: begin
        if (legal) begin
          div_nx = cfg.cfg_div;
          if (cfg.cfg_en) begin
            state_nx = RUN;
            cnt_nx   = '0;
          end
        end
      end
      RUN, PEND: begin
        if (bnd) begin
          cnt_nx = '0;
          // a boundary request in RUN is applied like a pending one
          if (state == PEND || legal) begin
            pdiv_nx = '0;
            pen_nx  = 1'b0;
            if (app_en) begin
              state_nx = RUN;
              div_nx   = app_div;
            end else begin
              state_nx = IDLE;
            end
          end
        end else begin
          cnt_nx = cnt + 1'b1;
          if (state == RUN && legal) begin
            pdiv_nx  = cfg.cfg_div;
            pen_nx   = cfg.cfg_en;
            state_nx = PEND;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    // outputs are registered from next-state so they align with cnt
    half_nx  = ({1'b0, div_nx} + 1'b1) >> 1;
    clk_p_nx = (state_nx != IDLE) && ({1'b0, cnt_nx} < half_nx);
    tick_nx  = (state_nx != IDLE) && (cnt_nx == div_nx - 1'b1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      cur_div       <= CNT_W'(DEF_DIV);
      pdiv          <= '0;
      pen           <= 1'b0;
      clk_p         <= 1'b0;
      cfg.cfg_ready <= 1'b1;
      cfg_err       <= 1'b0;
      period_tick   <= 1'b0;
      div_active    <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      cur_div       <= div_nx;
      pdiv          <= pdiv_nx;
      pen           <= pen_nx;
      clk_p         <= clk_p_nx;
      cfg.cfg_ready <= (state_nx != PEND);
      cfg_err       <= acc && (cfg.cfg_div < CNT_W'(2));
      period_tick   <= tick_nx;
      div_active    <= (state_nx != IDLE);
    end
  end

`ifdef CLK_DIV_DUTY50_EN
  logic clk_n;

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_n <= 1'b0;
    end else begin
      clk_n <= clk_p;
    end
  end

  assign clk_out = cur_div[0] ? (clk_p & clk_n) : clk_p;
`else
  assign clk_out = clk_p;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus random
// requests, every cycle compared against a period-level reference model.
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rstn;
  logic             clk_out;
  logic             div_active;
  logic [CNT_W-1:0] cur_div;
  logic             cfg_err;
  logic             period_tick;

  int n_assert;
  int n_fail;

  // reference model: position inside the current period
  bit m_run;
  int m_div;
  int m_pos;
  bit m_pv;
  int m_pdiv;
  bit m_pen;
  bit m_err;

  int hi;
  int tk;
  int n;

  clk_div_if #(.CNT_W(CNT_W)) ifc ();

  clk_div_ctrl #(
    .CNT_W   (CNT_W),
    .DEF_DIV (5)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg         (ifc),
    .clk_out     (clk_out),
    .div_active  (div_active),
    .cur_div     (cur_div),
    .cfg_err     (cfg_err),
    .period_tick (period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_div  = 5;
    m_pos  = 0;
    m_pv   = 0;
    m_pdiv = 0;
    m_pen  = 0;
    m_err  = 0;
  endtask

  task automatic model_step();
    bit acc;
    bit legal;
    bit take;
    int d;
    bit e;
    if (!rstn) begin
      model_reset();
      return;
    end
    acc   = ifc.cfg_valid && !m_pv;
    legal = acc && (int'(ifc.cfg_div) >= 2);
    m_err = acc && (int'(ifc.cfg_div) < 2);
    take  = 0;
    d     = 0;
    e     = 0;
    if (!m_run) begin
      if (legal) begin
        m_div = int'(ifc.cfg_div);
        if (ifc.cfg_en) begin
          m_run = 1;
          m_pos = 0;
        end
      end
    end else if (m_pos == m_div - 1) begin
      if (m_pv) begin
        d = m_pdiv; e = m_pen; take = 1;
      end else if (legal) begin
        d = int'(ifc.cfg_div); e = ifc.cfg_en; take = 1;
      end
      m_pos = 0;
      m_pv  = 0;
      if (take) begin
        if (e) m_div = d;
        else m_run = 0;
      end
    end else begin
      m_pos++;
      if (legal) begin
        m_pv   = 1;
        m_pdiv = int'(ifc.cfg_div);
        m_pen  = ifc.cfg_en;
      end
    end
  endtask

  function automatic bit exp_clk();
    bit e;
    e = m_run && (m_pos < (m_div + 1) / 2);
`ifdef CLK_DIV_DUTY50_EN
    // sampled just after posedge: odd ratios rise half a cycle late
    if ((m_div % 2) == 1 && m_pos == 0) e = 0;
`endif
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("clk_out", 32'(clk_out), 32'(exp_clk()));
    chk("tick", 32'(period_tick),
        32'(m_run && m_pos == m_div - 1));
    chk("active", 32'(div_active), 32'(m_run));
    chk("ready", 32'(ifc.cfg_ready), 32'(!m_pv));
    chk("cur_div", 32'(cur_div), 32'(m_div));
    chk("err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic req(input int d, input bit e);
    ifc.cfg_valid = 1'b1;
    ifc.cfg_div   = CNT_W'(d);
    ifc.cfg_en    = e;
    cyc();
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic wait_pos(input int d, input int p);
    int k;
    k = 0;
    while (!(m_run && m_div == d && m_pos == p) && k < 100) begin
      cyc();
      k++;
    end
    chk("wait_bound", 32'(k < 100), 32'd1);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    ifc.cfg_valid = 1'b0;
    ifc.cfg_div   = '0;
    ifc.cfg_en    = 1'b0;
    rstn          = 1'b0;
    model_reset();
    #12;
    chk("rst_clk", 32'(clk_out), 32'd0);
    chk("rst_div", 32'(cur_div), 32'd5);
    chk("rst_ready", 32'(ifc.cfg_ready), 32'd1);
    chk("rst_active", 32'(div_active), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) cyc();

    // 1: start at N=5
    req(5, 1);
    wait_pos(5, 0);
    hi = 0; tk = 0;
    repeat (5) begin
      hi += int'(clk_out);
      tk += int'(period_tick);
      cyc();
    end
`ifdef CLK_DIV_DUTY50_EN
    chk("s1_high", 32'(hi), 32'd2);
`else
    chk("s1_high", 32'(hi), 32'd3);
`endif
    chk("s1_ticks", 32'(tk), 32'd1);
    chk("s1_active", 32'(div_active), 32'd1);

    // 2: mid-period change to 4
    wait_pos(5, 1);
    req(4, 1);
    chk("s2_ready", 32'(ifc.cfg_ready), 32'd0);
    wait_pos(4, 0);
    chk("s2_div", 32'(cur_div), 32'd4);
    hi = 0;
    repeat (4) begin
      hi += int'(clk_out);
      cyc();
    end
    chk("s2_high", 32'(hi), 32'd2);

    // 3: illegal ratio
    req(1, 1);
    chk("s3_err", 32'(cfg_err), 32'd1);
    cyc();
    chk("s3_err_off", 32'(cfg_err), 32'd0);
    chk("s3_div", 32'(cur_div), 32'd4);
    chk("s3_ready", 32'(ifc.cfg_ready), 32'd1);

    // 4: stop at N=7 completes the period
    req(7, 1);
    wait_pos(7, 2);
    req(7, 0);
    n = 0;
    while (div_active && n < 50) begin
      cyc();
      n++;
    end
    chk("s4_tail", 32'(n), 32'd4);
    chk("s4_clk", 32'(clk_out), 32'd0);
    chk("s4_ready", 32'(ifc.cfg_ready), 32'd1);

    // 5: async reset while clk_out high
    req(3, 1);
    wait_pos(3, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk("s5_clk", 32'(clk_out), 32'd0);
    chk("s5_div", 32'(cur_div), 32'd5);
    chk("s5_active", 32'(div_active), 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) cyc();
    chk("s5_ready", 32'(ifc.cfg_ready), 32'd1);

    // 6: change on the boundary cycle
    req(6, 1);
    wait_pos(6, 5);
    req(9, 1);
    chk("s6_ready", 32'(ifc.cfg_ready), 32'd1);
    chk("s6_div", 32'(cur_div), 32'd9);
    repeat (12) cyc();

    // random requests, model compares every cycle
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0)
        req(int'($urandom_range(0, 14)), $urandom_range(0, 4) != 0);
      else
        cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
